// File: rtl/amiga_kbd_pkg.sv
// amiga_kbd_pkg: shared states, keycodes, timing defaults and bit-order helper for the keyboard transmitter
package amiga_kbd_pkg;
  typedef enum logic [3:0] {
    PU_RESYNC, IDLE, SETUP, LOW, HIGH, HS_SETTLE, HS_WAIT, HS_END, RESYNC
  } state_e;
  typedef enum logic [2:0] {
    J_PU_SYNC, J_PU_START, J_PU_END, J_SYNC, J_LOST, J_RETRY, J_NORMAL
  } job_e;
  localparam logic [7:0] KC_LOST_SYNC = 8'hF9;
  localparam logic [7:0] KC_PU_START = 8'hFD;
  localparam logic [7:0] KC_PU_END = 8'hFE;
  localparam int T_SETUP_DEF = 143;
  localparam int T_LOW_DEF = 143;
  localparam int T_HIGH_DEF = 143;
  localparam int T_HS_TIMEOUT_DEF = 1023730;
  localparam int CW_DEF = 20;
  localparam int T_SETTLE = 3;
  function automatic logic [7:0] kbd_rot(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction
endpackage

// File: rtl/amiga_kbd_bit_timer.sv
// amiga_kbd_bit_timer: phase down-counter; a load of N makes exp_o rise on the Nth cycle after the load
module amiga_kbd_bit_timer #(
  parameter int CW = 20,
  parameter int RST_VAL = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] val_i,
  output logic          exp_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  // reload on phase entry, otherwise count down and park at zero
  always_comb cnt_d = load_i ? val_i - CW'(1) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
  // counter register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= CW'(RST_VAL);
    else cnt_q <= cnt_d;
  assign exp_o = cnt_q == '0;
endmodule

// File: rtl/amiga_kbd_tx.sv
// amiga_kbd_tx: keyboard-side KCLK/KDAT serial transmitter with handshake, resync and power-up stream
module amiga_kbd_tx
  import amiga_kbd_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_LOW = T_LOW_DEF,
  parameter int T_HIGH = T_HIGH_DEF,
  parameter int T_HS_TIMEOUT = T_HS_TIMEOUT_DEF,
  parameter int CW = CW_DEF
) (
  input  logic       CLK,
  input  logic       _RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       KCLK_OE,
  output logic       KDAT_OE,
  input  logic       KDAT_IN,
  output logic       SYNC_LOST
);
  state_e state_q, state_d;
  job_e job_q, job_d;
  logic [7:0] sr_q, sr_d, retry_q, retry_d;
  logic [2:0] bit_q, bit_d;
  logic kclk_q, kclk_d, kdat_q, kdat_d;
  logic [1:0] sync_q;
  logic kd_s, tmr_exp, tmr_load, sync_lost;
  logic [CW-1:0] tmr_val;
  assign kd_s = sync_q[1];
  assign tmr_load = state_d != state_q;
  // phase length of the state being entered; the settle covers synchronizer latency after KDAT release
  always_comb tmr_val = CW'(state_d == LOW ? T_LOW : state_d == HIGH ? T_HIGH :
                            state_d == HS_SETTLE ? T_SETTLE : state_d == HS_WAIT ? T_HS_TIMEOUT : T_SETUP);
  amiga_kbd_bit_timer #(.CW(CW), .RST_VAL(T_SETUP)) u_tmr (
    .clk_i (CLK),
    .rst_ni(_RST),
    .load_i(tmr_load),
    .val_i (tmr_val),
    .exp_o (tmr_exp)
  );
  // next-state: bit timing, handshake detection, resync and follow-on byte selection
  always_comb begin
    state_d = state_q;
    job_d = job_q;
    sr_d = sr_q;
    bit_d = bit_q;
    retry_d = retry_q;
    sync_lost = 1'b0;
    case (state_q)
      IDLE:
        if (TX_VALID && kd_s) begin
          state_d = SETUP;
          job_d = J_NORMAL;
          retry_d = TX_DATA;
          sr_d = kbd_rot(TX_DATA);
          bit_d = 3'd7;
        end
      PU_RESYNC, RESYNC, SETUP: if (tmr_exp) state_d = LOW;
      LOW: if (tmr_exp) state_d = HIGH;
      HIGH:
        if (tmr_exp) begin
          if (bit_q == 3'd0) state_d = HS_SETTLE;
          else begin
            state_d = SETUP;
            sr_d = {sr_q[6:0], 1'b0};
            bit_d = bit_q - 3'd1;
          end
        end
      HS_SETTLE: if (tmr_exp) state_d = HS_WAIT;
      HS_WAIT:
        if (!kd_s) state_d = HS_END;
        else if (tmr_exp) begin
          sr_d = 8'h80;
          bit_d = 3'd0;
          if (job_q inside {J_PU_SYNC, J_PU_START, J_PU_END}) begin
            state_d = PU_RESYNC;
            job_d = J_PU_SYNC;
          end else begin
            state_d = RESYNC;
            job_d = J_SYNC;
            sync_lost = job_q != J_SYNC;
          end
        end
      HS_END:
        if (kd_s) begin
          state_d = job_q inside {J_PU_END, J_RETRY, J_NORMAL} ? IDLE : SETUP;
          job_d = job_q == J_PU_SYNC ? J_PU_START : job_q == J_PU_START ? J_PU_END :
                  job_q == J_SYNC ? J_LOST : J_RETRY;
          sr_d = kbd_rot(job_q == J_PU_SYNC ? KC_PU_START : job_q == J_PU_START ? KC_PU_END :
                         job_q == J_SYNC ? KC_LOST_SYNC : retry_q);
          bit_d = 3'd7;
        end
      default: state_d = PU_RESYNC;
    endcase
    kdat_d = (state_d inside {PU_RESYNC, RESYNC, SETUP, LOW, HIGH}) && sr_d[7];
    kclk_d = state_d == LOW;
  end
  // state, datapath, registered open-collector enables and KDAT synchronizer
  always_ff @(posedge CLK or negedge _RST)
    if (!_RST) begin
      state_q <= PU_RESYNC;
      job_q <= J_PU_SYNC;
      sr_q <= 8'h80;
      bit_q <= 3'd0;
      retry_q <= 8'h00;
      kclk_q <= 1'b0;
      kdat_q <= 1'b0;
      sync_q <= 2'b11;
    end else begin
      state_q <= state_d;
      job_q <= job_d;
      sr_q <= sr_d;
      bit_q <= bit_d;
      retry_q <= retry_d;
      kclk_q <= kclk_d;
      kdat_q <= kdat_d;
      sync_q <= {sync_q[0], KDAT_IN};
    end
  assign TX_READY = state_q == IDLE && kd_s;
  assign KCLK_OE = kclk_q;
  assign KDAT_OE = kdat_q;
  assign SYNC_LOST = sync_lost;
endmodule
